// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor
// ----------------
// Lock detector and frequency meter for the digital PLL. Runs on the DCO
// output clock, counts DCO cycles per period of the reference osc, and
// compares that count against the feedback ratio div. Reports the measured
// ratio, a lock flag and a loss-of-reference flag. Purely observational:
// nothing here feeds back into the loop trim.
//
// Build option:
//   PLL_LOCK_MON_HYST_EN  when defined, LOCKED tolerates one isolated bad
//                         measurement; two consecutive bad ones drop lock.
//                         When undefined, any bad measurement drops lock.
//                         A reference timeout drops lock in both builds.

module pll_lock_monitor #(
    parameter int CNT_W       = 7,   // period counter / meas width (>= 5)
    parameter int TOL         = 1,   // allowed |meas - div|
    parameter int LOCK_CYCLES = 4    // consecutive good periods to lock, 1..15
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             enable,
    input  logic             osc,
    input  logic [4:0]       div,
    output logic [CNT_W-1:0] meas,
    output logic             meas_valid,
    output logic             locked,
    output logic             osc_lost
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // One extra bit so div + TOL can never wrap during the window test.
    localparam int               EW     = CNT_W + 1;
    localparam logic [CNT_W-1:0] SAT    = {CNT_W{1'b1}};
    localparam logic [EW-1:0]    TOL_E  = EW'(TOL);
    localparam logic [3:0]       LOCK_N = 4'(LOCK_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             primed;
    logic [3:0]       good_run;

    logic             osc_s1;
    logic             osc_s2;
    logic             osc_d;
    logic             osc_rise;
    logic             saturated;

    logic [EW-1:0]    div_e;
    logic [EW-1:0]    cnt_e;
    logic [EW-1:0]    win_lo;
    logic [EW-1:0]    win_hi;
    logic             good;
    logic [3:0]       good_run_inc;
    logic             drop_on_bad;

    // Reference synchronizer and rising-edge detect; free-running under enable.
    // NOTE: only resetb clears these flops. Gating them with enable would let a
    // stale osc level fake a rising edge the moment the monitor is re-enabled.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            osc_s1 <= 1'b0;
            osc_s2 <= 1'b0;
            osc_d  <= 1'b0;
        end else begin
            osc_s1 <= osc;
            osc_s2 <= osc_s1;
            osc_d  <= osc_s2;
        end
    end

    assign osc_rise  = osc_s2 & ~osc_d;
    assign saturated = (cnt == SAT);

    // Tolerance window test on the count about to be captured as meas.
    // NOTE: every variable gets a value before any condition is evaluated, so
    // no path through this block can leave a latch behind.
    always_comb begin
        div_e  = EW'(div);
        cnt_e  = EW'(cnt);
        win_hi = div_e + TOL_E;
        win_lo = (div_e >= TOL_E) ? (div_e - TOL_E) : '0;
        good   = (div_e != '0) && (cnt_e >= win_lo) && (cnt_e <= win_hi);
    end

    assign good_run_inc = good_run + 4'd1;

`ifdef PLL_LOCK_MON_HYST_EN
    logic strike;

    // Strike flag: remembers one bad measurement while locked; a good one
    // forgives it, a second bad one is what drops lock.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            strike <= 1'b0;
        end else if (!enable || state == IDLE) begin
            strike <= 1'b0;
        end else if (osc_rise) begin
            if (primed && state == LOCKED) begin
                // good -> 0, first bad -> 1, second bad -> 0 (lock drops)
                strike <= !good && !strike;
            end
        end else if (saturated) begin
            strike <= 1'b0;
        end
    end

    assign drop_on_bad = strike;
`else
    assign drop_on_bad = 1'b1;
`endif

    // Main FSM: period counter, priming, measurement capture, lock and timeout.
    // Priority: enable low, then osc edge, then counter saturation.
    // NOTE: all state updates here are non-blocking so every register samples
    // the pre-edge values of its neighbours, as real flops do.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            cnt        <= '0;
            primed     <= 1'b0;
            good_run   <= '0;
            meas       <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            osc_lost   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;

            if (!enable) begin
                state    <= IDLE;
                cnt      <= '0;
                primed   <= 1'b0;
                good_run <= '0;
                meas     <= '0;
                locked   <= 1'b0;
                osc_lost <= 1'b0;
            end else if (state == IDLE) begin
                // Counting starts once we are in ACQUIRE; all state is still 0.
                state <= ACQUIRE;
            end else if (osc_rise) begin
                cnt <= CNT_W'(1);
                if (!primed) begin
                    // Priming edge: opens the first period, produces no meas.
                    primed   <= 1'b1;
                    osc_lost <= 1'b0;
                end else begin
                    meas       <= cnt;
                    meas_valid <= 1'b1;
                    case (state)
                        ACQUIRE: begin
                            if (good) begin
                                good_run <= good_run_inc;
                                if (good_run_inc >= LOCK_N) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                good_run <= '0;
                            end
                        end
                        LOCKED: begin
                            if (!good && drop_on_bad) begin
                                state    <= ACQUIRE;
                                locked   <= 1'b0;
                                good_run <= '0;
                            end
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end else if (saturated) begin
                // Reference timeout: no osc edge for a full counter range.
                state    <= ACQUIRE;
                osc_lost <= 1'b1;
                locked   <= 1'b0;
                good_run <= '0;
                primed   <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Testbench for pll_lock_monitor. osc is driven on falling clock edges so
// every reference period is an exact number of clock cycles. A reference
// model of the lock rules pushes the expected meas/locked pair each time a
// measuring osc edge is driven; a monitor pops and compares on meas_valid.
// Builds with or without PLL_LOCK_MON_HYST_EN.

module tb_pll_lock_monitor;

    localparam int TOL_M  = 1;
    localparam int LOCK_M = 4;
`ifdef PLL_LOCK_MON_HYST_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetb;
    logic       enable;
    logic       osc;
    logic [4:0] div;
    logic [6:0] meas;
    logic       meas_valid;
    logic       locked;
    logic       osc_lost;

    pll_lock_monitor #(
        .CNT_W      (7),
        .TOL        (TOL_M),
        .LOCK_CYCLES(LOCK_M)
    ) dut (
        .clock     (clock),
        .resetb    (resetb),
        .enable    (enable),
        .osc       (osc),
        .div       (div),
        .meas      (meas),
        .meas_valid(meas_valid),
        .locked    (locked),
        .osc_lost  (osc_lost)
    );

    always #5 clock = ~clock;

    typedef struct {
        int meas;
        int locked;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_primed;
    int m_run;
    bit m_locked;
    bit m_strike;
    int last_gap;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic bit is_good(input int m, input int d);
        int lo;
        lo = (d >= TOL_M) ? d - TOL_M : 0;
        return (d != 0) && (m >= lo) && (m <= d + TOL_M);
    endfunction

    task automatic model_clear();
        m_primed = 1'b0;
        m_run    = 0;
        m_locked = 1'b0;
        m_strike = 1'b0;
    endtask

    task automatic model_measure(input int m);
        bit g;
        g = is_good(m, int'(div));
        if (!m_locked) begin
            if (g) begin
                m_run++;
                if (m_run >= LOCK_M) m_locked = 1'b1;
            end else begin
                m_run = 0;
            end
        end else if (g) begin
            m_strike = 1'b0;
        end else if (HYST && !m_strike) begin
            m_strike = 1'b1;
        end else begin
            m_locked = 1'b0;
            m_run    = 0;
            m_strike = 1'b0;
        end
        sb.push_back('{m, int'(m_locked)});
    endtask

    // Drive one osc rising edge, then hold for p clock cycles (caller sits at
    // a falling edge). The edge closes the previous period of last_gap cycles.
    task automatic osc_edge(input int p);
        osc = 1'b1;
        if (m_primed) model_measure(last_gap);
        else          m_primed = 1'b1;
        last_gap = p;
        repeat (p / 2) @(negedge clock);
        osc = 1'b0;
        repeat (p - p / 2) @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_meas"},       int'(meas),       0);
        check({tag, "_meas_valid"}, int'(meas_valid), 0);
        check({tag, "_locked"},     int'(locked),     0);
        check({tag, "_osc_lost"},   int'(osc_lost),   0);
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (resetb === 1'b1 && meas_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_meas_valid", int'(meas_valid), 0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_meas",     int'(meas),     mon_e.meas);
                check("sb_locked",   int'(locked),   mon_e.locked);
                check("sb_osc_lost", int'(osc_lost), 0);
            end
        end
    end

    initial begin
        int waited;
        resetb   = 1'b0;
        enable   = 1'b0;
        osc      = 1'b0;
        div      = 5'd8;
        last_gap = 0;
        model_clear();

        // Reset state
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        resetb = 1'b1;
        @(negedge clock);
        enable = 1'b1;
        repeat (3) @(negedge clock);

        // Lock acquisition: prime + 4 good periods of 8
        repeat (4) osc_edge(8);
        check("acq_not_yet", int'(locked), 0);
        osc_edge(8);
        check("acq_locked", int'(locked), 1);

        // Tolerance boundary: 7/9 alternation holds lock
        osc_edge(7); osc_edge(9); osc_edge(7); osc_edge(9);
        osc_edge(7); osc_edge(9); osc_edge(8);
        check("tol_hold", int'(locked), 1);

        // Single period of 10
        osc_edge(10); osc_edge(8);
        check("single_bad", int'(locked), HYST ? 1 : 0);
        repeat (5) osc_edge(8);
        check("relock", int'(locked), 1);

        // Two periods of 10 drop lock in both builds
        osc_edge(10); osc_edge(10); osc_edge(8);
        check("double_bad", int'(locked), 0);

        // Loss of reference
        repeat (6) osc_edge(8);
        check("pre_timeout_locked", int'(locked), 1);
        repeat (110) @(negedge clock);
        check("no_early_timeout", int'(osc_lost), 0);
        waited = 0;
        while (osc_lost !== 1'b1 && waited < 60) begin
            @(negedge clock);
            waited++;
        end
        check("timeout_osc_lost", int'(osc_lost), 1);
        check("timeout_locked",   int'(locked),   0);
        model_clear();
        osc_edge(8);
        check("osc_lost_cleared", int'(osc_lost), 0);

        // div = 0 is never good
        div = 5'd0;
        repeat (6) osc_edge(8);
        check("div0_meas",   int'(meas),   8);
        check("div0_nolock", int'(locked), 0);

        // Enable dropped mid-period while locked
        div = 5'd8;
        repeat (5) osc_edge(8);
        check("pre_disable_locked", int'(locked), 1);
        osc_edge(5);
        enable = 1'b0;
        @(negedge clock);
        check_all_zero("disable");
        check("disable_sb_empty", sb.size(), 0);
        model_clear();
        repeat (4) @(negedge clock);
        enable = 1'b1;
        repeat (3) @(negedge clock);
        repeat (4) osc_edge(8);
        check("reenable_not_yet", int'(locked), 0);
        repeat (2) osc_edge(8);
        check("reenable_locked", int'(locked), 1);

        // Async reset between clock edges
        check("pre_reset_meas", int'(meas), 8);
        #2 resetb = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clock);
        resetb = 1'b1;
        model_clear();
        repeat (2) @(negedge clock);
        check("post_reset_locked", int'(locked), 0);

        check("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
